tx_fsm: RTL and testbench
=========================

Name: tx_fsm

Overview:
- ARQ-style transmit block: a small nibble FIFO feeds a transmit state machine.
- Each read transaction resolves from a per-read error mode:
  - good: ACK and pop.
  - corrupted: ACK and pop, with corrupted data sent.
  - NACK: keep the head entry for retransmission.
- Sits in the standard 8-in/8-out/8-bidir user-project wrapper; all I/O is packed into ui_in/uo_out/uio_*.

Parameters:
- DEPTH, 8, FIFO entries (power of 2).
- MAX_RETRY, 3, consecutive NACKs of one entry before it is dropped.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ui_in  input  8  [7]=wr_en, [6]=rd_en, [5:2]=data_in, [1:0]=err_mode.
- uo_out  output  8  [3:0]=tx_data, [4]=tx_valid, [5]=ack, [6]=nack, [7]=fault.
- uio_in  input  8  unused.
- uio_out  output  8  [3:0]=count (0..DEPTH), [4]=full, [5]=empty, [6]=drop, [7]=retrying.
- uio_oe  output  8  constant 8'hFF.
- ena  input  1  ignored; the block always runs.

Behaviour:
Reset (async assert, sync release):
- FIFO pointers, count and retry_cnt go to 0; state = IDLE.
- uo_out = 0; uio_out = 8'h20 (only empty set).

Write path:
- wr_en high at a rising edge pushes data_in if not full.
- Write when full is silently ignored; FIFO contents are unchanged.
- Write is independent of the FSM. A same-edge push and pop are both applied, and count is unchanged.

FSM states: IDLE, TX.
- IDLE:
  - rd_en high and FIFO not empty → TX.
  - rd_en high on empty FIFO → stay IDLE; no outputs pulse.
- TX: lasts exactly one cycle, then returns to IDLE. rd_en is ignored while in TX.
  - rd_en held high therefore yields one transaction every 2 cycles.
- err_mode is sampled on the same edge as the accepted rd_en.

Transaction outputs:
- Registered; valid during the TX cycle, i.e. one cycle after the accepting edge.
- tx_valid=1 only in TX. ack, nack, fault and drop are single-cycle pulses in TX. tx_data holds its last value otherwise.
- err_mode=00 (good): tx_data=head, ack=1; pop; retry_cnt←0.
- err_mode=01 (corrupted): tx_data=head XOR 4'hF, ack=1, fault=1; pop; retry_cnt←0.
- err_mode=10 or 11 (NACK/lost): tx_data=head, nack=1; no pop; retry_cnt increments.
- Retry limit (see Optional Feature):
  - If this NACK brings retry_cnt to MAX_RETRY: pop instead, drop=1, fault=1, retry_cnt←0.

Status outputs (live, registered from state):
- count = entries stored; full = count==DEPTH; empty = count==0.
- retrying = retry_cnt!=0.

Pointer and width rules:
- Pointers wrap modulo DEPTH.
- count uses log2(DEPTH)+1 bits; for the default DEPTH=8 it maps directly to uio_out[3:0].

Reset mid-transaction:
- Aborts immediately; FIFO contents are discarded.

Optional Feature:
Macro RETRY_LIMIT_EN.
- Defined: MAX_RETRY drop rule is active as described above.
- Undefined:
  - Unlimited retransmission; the head is never dropped by NACKs.
  - drop is tied 0.
  - retry_cnt saturates at 3 and still drives retrying.

Test Plan:
- Reset, then idle: uo_out=00, uio_out=20, uio_oe=FF.
- Push 0,A,3,2 on consecutive edges → count=4, empty=0, full=0. Then 1-cycle rd_en with err_mode=00 → next cycle tx_data=0, tx_valid=1, ack=1; count=3.
- 1-cycle rd_en with err_mode=01 → tx_data=5 (A^F), ack=1, fault=1; count=2.
- rd_en with err_mode=10 → tx_data=3, nack=1, count stays 2, retrying=1. Then rd_en with 00 → tx_data=3, ack=1, retrying=0, count=1. Then rd_en with 00 → tx_data=2, count=0, empty=1.
- rd_en on empty FIFO with any err_mode → no tx_valid/ack/nack pulse, state stays IDLE.
- With RETRY_LIMIT_EN: push 7, issue 3 NACK reads → reads 1–2 give nack only; read 3 gives nack=1, drop=1, fault=1, count=0. Fill with 9 writes → full=1, count=8, 9th write ignored.

Source files
------------

// File: rtl/tx_fsm_if.sv
// rtl/tx_fsm_if.sv - packed user-project pin bundle for the ARQ transmit block (master drives ui_in)
interface tx_fsm_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in,
        output uio_in,
        output ena,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        input  ena,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/tx_fsm.sv
// rtl/tx_fsm.sv - ARQ transmit block: nibble FIFO plus IDLE/TX state machine; RETRY_LIMIT_EN enables drop after MAX_RETRY NACKs
module tx_fsm #(
    parameter int DEPTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    tx_fsm_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        TX   = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [RW-1:0]  retry_cnt;
    logic [RW-1:0]  retry_nxt;

    logic [3:0]     tx_data_q;
    logic [3:0]     tx_data_nxt;
    logic           ack_q;
    logic           ack_nxt;
    logic           nack_q;
    logic           nack_nxt;
    logic           fault_q;
    logic           fault_nxt;
    logic           drop_q;
    logic           drop_nxt;

    logic           wr_en;
    logic           rd_en;
    logic [3:0]     data_in;
    logic [1:0]     err_mode;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [3:0]     head;
    logic [7:0]     count_ext;
    logic           unused_ok;

    assign wr_en    = bus.ui_in[7];
    assign rd_en    = bus.ui_in[6];
    assign data_in  = bus.ui_in[5:2];
    assign err_mode = bus.ui_in[1:0];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign head  = mem[rd_ptr];

    // Next state and the transaction result, resolved on the accepting edge
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        retry_nxt   = retry_cnt;
        tx_data_nxt = tx_data_q;
        ack_nxt     = 1'b0;
        nack_nxt    = 1'b0;
        fault_nxt   = 1'b0;
        drop_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en && !empty) begin
                    state_nxt = TX;
                    case (err_mode)
                        2'b00: begin
                            tx_data_nxt = head;
                            ack_nxt     = 1'b1;
                            pop         = 1'b1;
                            retry_nxt   = '0;
                        end
                        2'b01: begin
                            tx_data_nxt = head ^ 4'hF;
                            ack_nxt     = 1'b1;
                            fault_nxt   = 1'b1;
                            pop         = 1'b1;
                            retry_nxt   = '0;
                        end
                        default: begin
                            tx_data_nxt = head;
                            nack_nxt    = 1'b1;
`ifdef RETRY_LIMIT_EN
                            // The NACK that reaches the limit gives up on this entry
                            if (retry_cnt == RW'(MAX_RETRY - 1)) begin
                                pop       = 1'b1;
                                drop_nxt  = 1'b1;
                                fault_nxt = 1'b1;
                                retry_nxt = '0;
                            end else begin
                                retry_nxt = retry_cnt + 1'b1;
                            end
`else
                            // Unlimited retransmission; counter only reports that retries happen
                            if (retry_cnt != RW'(3)) begin
                                retry_nxt = retry_cnt + 1'b1;
                            end
`endif
                        end
                    endcase
                end
            end
            TX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, retry counter and registered transaction outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            retry_cnt <= '0;
            tx_data_q <= '0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            fault_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            tx_data_q <= tx_data_nxt;
            ack_q     <= ack_nxt;
            nack_q    <= nack_nxt;
            fault_q   <= fault_nxt;
            drop_q    <= drop_nxt;
        end
    end

    // FIFO storage; contents are meaningless after reset because pointers restart
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign count_ext = 8'(count);

    assign bus.uo_out  = {fault_q, nack_q, ack_q, (state == TX), tx_data_q};
    assign bus.uio_out = {(retry_cnt != '0), drop_q, empty, full, count_ext[3:0]};
    assign bus.uio_oe  = 8'hFF;

    assign unused_ok = ^{bus.uio_in, bus.ena, count_ext[7:4]};

endmodule

// File: tb/tb_tx_fsm.sv
// tb/tb_tx_fsm.sv - directed scoreboard bench for tx_fsm
module tb_tx_fsm;
    localparam int DEPTH     = 8;
    localparam int MAX_RETRY = 3;
`ifdef RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    typedef struct {
        logic [3:0] data;
        logic       ack;
        logic       nack;
        logic       fault;
        logic       drop;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [3:0] model[$];
    int         model_retry;
    logic [3:0] last_data;
    exp_t       sb[$];

    tx_fsm_if bus ();

    tx_fsm #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic report(input string tag, input bit ok, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] e;
        e = {(model_retry != 0), 1'b0, (model.size() == 0), (model.size() == DEPTH), 4'(model.size())};
        report(tag, bus.uio_out === e, bus.uio_out, e);
    endtask

    task automatic push(input logic [3:0] d);
        bus.ui_in = {2'b10, d, 2'b00};
        tick();
        bus.ui_in = 8'h00;
        if (model.size() < DEPTH) model.push_back(d);
    endtask

    function automatic exp_t model_read(input logic [1:0] mode);
        exp_t e;
        e.data = model[0];
        e.ack = 1'b0; e.nack = 1'b0; e.fault = 1'b0; e.drop = 1'b0;
        if (mode == 2'b00) begin
            e.ack = 1'b1;
            void'(model.pop_front());
            model_retry = 0;
        end else if (mode == 2'b01) begin
            e.data = model[0] ^ 4'hF;
            e.ack = 1'b1;
            e.fault = 1'b1;
            void'(model.pop_front());
            model_retry = 0;
        end else begin
            e.nack = 1'b1;
            if (LIMIT && model_retry + 1 == MAX_RETRY) begin
                e.drop = 1'b1;
                e.fault = 1'b1;
                void'(model.pop_front());
                model_retry = 0;
            end else if (LIMIT || model_retry < 3) begin
                model_retry++;
            end
        end
        return e;
    endfunction

    task automatic compare_tx(input string tag);
        exp_t e;
        int waited;
        waited = 0;
        while (!bus.uo_out[4] && waited < 4) begin
            tick();
            waited++;
        end
        report({tag, "_tx_valid"}, bus.uo_out[4] === 1'b1, bus.uo_out[4], 1'b1);
        if (bus.uo_out[4] && sb.size() != 0) begin
            e = sb.pop_front();
            report({tag, "_data"},  bus.uo_out[3:0] === e.data,  bus.uo_out[3:0], e.data);
            report({tag, "_ack"},   bus.uo_out[5]   === e.ack,   bus.uo_out[5],   e.ack);
            report({tag, "_nack"},  bus.uo_out[6]   === e.nack,  bus.uo_out[6],   e.nack);
            report({tag, "_fault"}, bus.uo_out[7]   === e.fault, bus.uo_out[7],   e.fault);
            report({tag, "_drop"},  bus.uio_out[6]  === e.drop,  bus.uio_out[6],  e.drop);
            last_data = e.data;
        end
        tick();
    endtask

    task automatic do_read(input string tag, input logic [1:0] mode);
        bit expect_tx;
        expect_tx = (model.size() != 0);
        if (expect_tx) sb.push_back(model_read(mode));
        bus.ui_in = {2'b01, 4'h0, mode};
        tick();
        bus.ui_in = 8'h00;
        if (expect_tx) begin
            compare_tx(tag);
        end else begin
            report({tag, "_idle_pulses"}, bus.uo_out[7:4] === 4'h0, bus.uo_out[7:4], 4'h0);
            report({tag, "_hold_data"},   bus.uo_out[3:0] === last_data, bus.uo_out[3:0], last_data);
            tick();
            report({tag, "_idle_after"},  bus.uo_out[7:4] === 4'h0, bus.uo_out[7:4], 4'h0);
        end
        check_status({tag, "_status"});
    endtask

    task automatic push_pop(input string tag, input logic [3:0] d);
        sb.push_back(model_read(2'b00));
        if (model.size() < DEPTH) model.push_back(d);
        bus.ui_in = {2'b11, d, 2'b00};
        tick();
        bus.ui_in = 8'h00;
        check_status({tag, "_status"});
        compare_tx(tag);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        model_retry = 0;
        last_data   = 4'h0;
        rst_n       = 1'b0;
        bus.ui_in   = 8'h00;
        bus.uio_in  = 8'h00;
        bus.ena     = 1'b1;

        repeat (2) tick();
        report("reset_uo_out",  bus.uo_out  === 8'h00, bus.uo_out,  8'h00);
        report("reset_uio_out", bus.uio_out === 8'h20, bus.uio_out, 8'h20);
        rst_n = 1'b1;
        tick();
        report("idle_uo_out",  bus.uo_out  === 8'h00, bus.uo_out,  8'h00);
        report("idle_uio_out", bus.uio_out === 8'h20, bus.uio_out, 8'h20);
        report("uio_oe",       bus.uio_oe  === 8'hFF, bus.uio_oe,  8'hFF);

        push(4'h0); push(4'hA); push(4'h3); push(4'h2);
        check_status("after_push4");
        do_read("rd_good", 2'b00);
        do_read("rd_corrupt", 2'b01);
        do_read("rd_nack", 2'b10);
        do_read("rd_retx", 2'b00);
        do_read("rd_last", 2'b00);

        do_read("empty_00", 2'b00);
        do_read("empty_01", 2'b01);
        do_read("empty_10", 2'b10);
        do_read("empty_11", 2'b11);

        push(4'h7);
        do_read("nack1", 2'b10);
        do_read("nack2", 2'b10);
        do_read("nack3", 2'b10);
        do_read("nack4", 2'b11);
        do_read("nack_ack", 2'b00);

        push(4'h1); push(4'h2);
        push_pop("pushpop", 4'h3);
        do_read("pp_drain1", 2'b00);
        do_read("pp_drain2", 2'b00);

        for (int i = 0; i < 9; i++) push(4'(4'h8 + i));
        check_status("full9");
        for (int i = 0; i < 8; i++) do_read("drain_full", 2'b00);
        do_read("drain_empty", 2'b00);

        push(4'h5); push(4'h6);
        bus.ui_in = {2'b01, 4'h0, 2'b00};
        tick();
        bus.ui_in = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        report("midtx_rst_uo_out",  bus.uo_out  === 8'h00, bus.uo_out,  8'h00);
        report("midtx_rst_uio_out", bus.uio_out === 8'h20, bus.uio_out, 8'h20);
        model.delete();
        sb.delete();
        model_retry = 0;
        last_data   = 4'h0;
        tick();
        rst_n = 1'b1;
        tick();
        push(4'h9);
        do_read("post_reset", 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
